// File: rtl/gt_cache_pkg.sv
// gt_cache_pkg: shared FSM state, address-field width helpers and byte extraction
// for the set-associative cache.
package gt_cache_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT, FILL} state_t;

    // Widest line the byte extractor accepts (256 bytes).
    localparam int MAX_LINE_W = 2048;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
        return addr_w - off_w(line_bytes) - idx_w(sets);
    endfunction

    // Byte k sits at the MSB end for k = 0.
    function automatic logic [7:0] get_byte(input logic [MAX_LINE_W-1:0] line,
                                            input int line_bytes, input int k);
        return line[8*(line_bytes-k)-1 -: 8];
    endfunction

endpackage

// File: rtl/gt_set_assoc_cache_if.sv
// gt_set_assoc_cache_if: lookup, line-fill, eviction and statistics signals of the cache.
interface gt_set_assoc_cache_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_hit;
    logic              fill_req_valid;
    logic [ADDR_W-1:0] fill_req_addr;
    logic              fill_valid;
    logic [LINE_W-1:0] fill_data;
    logic              evict_valid;
    logic [ADDR_W-1:0] evict_addr;
    logic [LINE_W-1:0] evict_data;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    modport slave (
        input  req_valid, req_addr, fill_valid, fill_data,
        output req_ready, rsp_valid, rsp_data, rsp_hit, fill_req_valid, fill_req_addr,
               evict_valid, evict_addr, evict_data, hit_count, miss_count
    );

    modport master (
        output req_valid, req_addr, fill_valid, fill_data,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, fill_req_valid, fill_req_addr,
               evict_valid, evict_addr, evict_data, hit_count, miss_count
    );
endinterface

// File: rtl/gt_cache_lru.sv
// gt_cache_lru: true-LRU age update for one set; age 0 is MRU, the maximum age is the victim.
module gt_cache_lru #(
    parameter int WAYS  = 2,
    parameter int AGE_W = 1
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages,
    input  logic [AGE_W-1:0]           touch,
    output logic [WAYS-1:0][AGE_W-1:0] next_ages,
    output logic [AGE_W-1:0]           max_way
);
    always_comb begin
        next_ages = ages;
        max_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages[w] < ages[touch]) next_ages[w] = ages[w] + AGE_W'(1);
            if (ages[w] > ages[max_way]) max_way = AGE_W'(w);
        end
        next_ages[touch] = '0;
    end
endmodule

// File: rtl/gt_set_assoc_cache.sv
// gt_set_assoc_cache: N-way set-associative byte-read cache with true-LRU, line fill and eviction.
// Define GT_CACHE_STATS_EN to build saturating hit/miss counters; otherwise they read 0.
module gt_set_assoc_cache
    import gt_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    gt_set_assoc_cache_if.slave bus
);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

    state_t            state, state_nx;
    logic [WAYS-1:0]   valid_mem [SETS];
    ages_t             age_mem   [SETS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [LINE_W-1:0] line_mem  [SETS][WAYS];

    logic [ADDR_W-1:0] addr_q;
    logic              hit_q;
    logic [WAY_W-1:0]  hit_way_q, vic_q;

    logic [IDX_W-1:0]  req_idx, cur_idx, lru_idx;
    logic [TAG_W-1:0]  req_tag, cur_tag;
    logic [OFF_W-1:0]  req_off, cur_off;
    logic              hit_any, inv_any, accept, fill_take, lookup_hit;
    logic [WAY_W-1:0]  hit_way, inv_way, max_way, touch, victim;
    ages_t             next_ages;

    assign req_off = bus.req_addr[OFF_W-1:0];
    assign req_idx = bus.req_addr[OFF_W +: IDX_W];
    assign req_tag = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign cur_off = addr_q[OFF_W-1:0];
    assign cur_idx = addr_q[OFF_W +: IDX_W];
    assign cur_tag = addr_q[ADDR_W-1 -: TAG_W];

    assign accept     = state == IDLE && bus.req_valid;
    assign fill_take  = state == MISS_WAIT && bus.fill_valid;
    assign lookup_hit = state == LOOKUP && hit_q;

    assign bus.req_ready     = state == IDLE;
    assign bus.fill_req_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Tag compare runs on the incoming address so the hit response can be registered at accept.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[req_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign lru_idx = (state == IDLE) ? req_idx : cur_idx;
    assign touch   = (state == LOOKUP) ? hit_way_q : vic_q;
    assign victim  = inv_any ? inv_way : max_way;

    gt_cache_lru #(.WAYS(WAYS), .AGE_W(WAY_W)) u_lru (
        .ages      (age_mem[lru_idx]),
        .touch     (touch),
        .next_ages (next_ages),
        .max_way   (max_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = bus.req_valid ? LOOKUP : IDLE;
            LOOKUP:    state_nx = hit_q ? IDLE : MISS_WAIT;
            MISS_WAIT: state_nx = bus.fill_valid ? FILL : MISS_WAIT;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q             <= '0;
            hit_q              <= 1'b0;
            hit_way_q          <= '0;
            vic_q              <= '0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_hit        <= 1'b0;
            bus.rsp_data       <= '0;
            bus.fill_req_valid <= 1'b0;
            bus.evict_valid    <= 1'b0;
            bus.evict_addr     <= '0;
            bus.evict_data     <= '0;
        end else begin
            bus.rsp_valid   <= accept ? hit_any : fill_take;
            bus.evict_valid <= fill_take && valid_mem[cur_idx][vic_q];
            if (accept) begin
                addr_q      <= bus.req_addr;
                hit_q       <= hit_any;
                hit_way_q   <= hit_way;
                vic_q       <= victim;
                bus.rsp_hit <= hit_any;
                if (hit_any)
                    bus.rsp_data <= get_byte(MAX_LINE_W'(line_mem[req_idx][hit_way]), LINE_BYTES, int'(req_off));
            end
            if (state == LOOKUP && !hit_q) bus.fill_req_valid <= 1'b1;
            if (fill_take) begin
                bus.fill_req_valid <= 1'b0;
                bus.rsp_hit        <= 1'b0;
                bus.rsp_data       <= get_byte(MAX_LINE_W'(bus.fill_data), LINE_BYTES, int'(cur_off));
                bus.evict_addr     <= {tag_mem[cur_idx][vic_q], cur_idx, {OFF_W{1'b0}}};
                bus.evict_data     <= line_mem[cur_idx][vic_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_mem[s][w] <= WAY_W'(w);
            end
        end else begin
            if (lookup_hit || fill_take) age_mem[cur_idx] <= next_ages;
            if (fill_take) valid_mem[cur_idx][vic_q] <= 1'b1;
        end
    end

    // Line storage carries no reset; validity alone says whether a way holds data.
    always_ff @(posedge clk) begin
        if (fill_take) begin
            tag_mem[cur_idx][vic_q]  <= cur_tag;
            line_mem[cur_idx][vic_q] <= bus.fill_data;
        end
    end

`ifdef GT_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hit_count  <= '0;
            bus.miss_count <= '0;
        end else begin
            if (accept && hit_any && !(&bus.hit_count)) bus.hit_count <= bus.hit_count + 32'd1;
            if (fill_take && !(&bus.miss_count)) bus.miss_count <= bus.miss_count + 32'd1;
        end
    end
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif

endmodule

// File: doc/gt_set_assoc_cache.md
# gt_set_assoc_cache

Parametrised N-way set-associative, byte-read cache replacing the fixed 32-line direct-mapped cache in the memory-hierarchy model. It sits between the address-trace driver and the next level (main memory or victim cache). Byte lookups use a valid/ready handshake. Misses issue a line-fill request and wait for the returned line. Displaced valid lines are pushed to the victim-cache port, and per-set true-LRU replacement is used.

## Interface
- ADDR_W, 32, address width
- LINE_BYTES, 32, bytes per line (power of 2); LINE_W = 8*LINE_BYTES
- SETS, 16, number of sets (power of 2)
- WAYS, 2, associativity (power of 2, 1..8; 1 = direct-mapped)
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request
- req_ready  out  1  cache idle, request accepted when both high
- req_addr  in  ADDR_W  byte address
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  8  returned byte
- rsp_hit  out  1  1 = hit, 0 = serviced by fill
- fill_req_valid  out  1  line fetch request, held until fill_valid
- fill_req_addr  out  ADDR_W  line-aligned miss address
- fill_valid  in  1  fill line present (memory or victim source)
- fill_data  in  LINE_W  fill line
- evict_valid  out  1  one-cycle pulse, displaced valid line
- evict_addr  out  ADDR_W  line-aligned address of displaced line
- evict_data  out  LINE_W  displaced line
- hit_count, miss_count  out  32 each  statistics (see Configuration)

## Operation
- Address split: offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = remaining bits. With defaults: tag [31:9], index [8:5], offset [4:0].
- Byte order within a line: byte k = line[LINE_W-1-8k -: 8]. Offset 0 is the MSB byte.
- State per way: valid bit, tag, line, age of log2(WAYS) bits. Reset clears all valid bits and sets the ages of each set to 0..WAYS-1 by way index. Line contents are not reset.
- FSM IDLE -> LOOKUP -> (hit) IDLE | (miss) MISS_WAIT -> FILL -> IDLE.
  - IDLE: req_ready=1. On handshake, latch addr and go to LOOKUP.
  - LOOKUP: compare the tags of all ways in the set.
    - Hit: rsp_valid=1, rsp_hit=1, rsp_data = selected byte, mark the way MRU, go to IDLE.
    - Miss: choose the victim way (lowest-index invalid way, else the way with maximum age) and go to MISS_WAIT.
  - MISS_WAIT: fill_req_valid=1 with fill_req_addr = latched addr with offset zeroed. Stay until fill_valid=1, then capture fill_data and go to FILL.
  - FILL: if the victim way is valid, pulse evict_valid with its tag/index address and old line. Write the new line, tag and valid=1, mark it MRU. Pulse rsp_valid with rsp_hit=0 and the byte from the new line. Go to IDLE.
- LRU update on touched way w with old age a: ways with age < a get +1, and w gets age 0. Ages stay a permutation.
- fill_valid outside MISS_WAIT is ignored. req_valid outside IDLE is not accepted.
- WAYS=1: the age logic degenerates, and the victim is always way 0.

## Timing
- Reset values: req_ready=1, all other outputs 0, counters 0.
- Hit: request accepted at edge N, rsp_valid high in cycle N+1, req_ready high again in cycle N+2.
- Miss: fill_req_valid rises in cycle N+2 and stays high until the edge where fill_valid=1 is sampled (edge M).
  - Minimum miss latency is fill_valid in the same cycle fill_req_valid rises, giving 3 cycles accept-to-response.
  - rsp_valid and evict_valid are high in cycle M+1. req_ready is high in cycle M+2.
- Response, evict and fill_req outputs are registered.
- Reset during MISS_WAIT or FILL: the FSM returns to IDLE asynchronously and fill_req_valid drops at once. No eviction or response is produced, and a later fill_valid is ignored.

## Configuration
- GT_CACHE_STATS_EN defined: hit_count increments on each hit response and miss_count on each miss response. Both saturate at 32'hFFFFFFFF and are cleared by reset.
- GT_CACHE_STATS_EN undefined: the ports remain but are tied to 0, and no counter logic is built.

## Structure
- Package gt_cache_pkg holds:
  - FSM state enum (IDLE, LOOKUP, MISS_WAIT, FILL);
  - localparam functions for offset, index and tag widths from ADDR_W/LINE_BYTES/SETS;
  - byte-extract function.
- One sub-module, gt_cache_lru: given the set's age vector and the touched way, it returns the next age vector and the max-age way. It is purely combinational.

## Test plan
- Cold miss on 0x0000_1234, fill line 256'h00..01..:
  - fill_req_addr=0x0000_1220, no evict_valid;
  - rsp_hit=0 with rsp_data = byte 20 of the fill line.
- Repeat 0x0000_1234 -> rsp_valid in cycle N+1, rsp_hit=1, same byte, fill_req_valid stays 0.
- WAYS=2, addresses 0x000, 0x200, 0x000, 0x400 (all index 0):
  - the third access hits;
  - the fourth evicts line 0x200 (evict_addr=0x200, evict_data = that line's fill).
- Assert RST_N low while in MISS_WAIT -> fill_req_valid=0 immediately. After release, a stale fill_valid produces no rsp_valid, and the same address misses again.
- Assert req_valid and fill_valid while in LOOKUP -> req_ready=0, fill ignored, only one response.
- GT_CACHE_STATS_EN defined: 3 hits and 2 misses give hit_count=3 and miss_count=2. With the macro undefined, both read 0.
